polar_encoder: RTL

- Iterative polar encoder. It is the transmit-side counterpart of the SC polar decoder datapath (F/G radix nodes).
- Builds the u-vector by inserting frozen zeros and streamed information bits at unfrozen positions, ascending index order.
- Applies x = u·F^{⊗n}, F = [[1,0],[1,1]], one butterfly stage per cycle.
- Presents the N-bit codeword on a valid/ready output. Used in the decoder testbench and the loop-back path.

---
 rtl/polar_pkg.sv | 24 ++
 rtl/polar_encoder_if.sv | 26 ++
 rtl/polar_enc_butterfly.sv | 24 ++
 rtl/polar_encoder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// Shared polar-code definitions: FSM state encoding, block-size limit and
// the bit-reversal index map used for frozen-mask / codeword layout.
package polar_pkg;

  localparam int unsigned MAX_N = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ENCODE = 2'd2,
    OUT    = 2'd3
  } polar_state_e;

  // Reverse the low nbits bits of x.
  function automatic int unsigned bitrev(input int unsigned x, input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < nbits; b++) begin
      r = r | (((x >> b) & 1) << (nbits - 1 - b));
    end
    return r;
  endfunction

endpackage

// File: rtl/polar_encoder_if.sv
// Frame-start, info-bit stream and codeword handshake bundle of the polar encoder.
interface polar_encoder_if #(
  parameter int unsigned N = 16
) ();

  logic         start_i;
  logic         start_ready_o;
  logic [N-1:0] frozen_mask_i;
  logic         info_bit_i;
  logic         info_valid_i;
  logic         info_ready_o;
  logic [N-1:0] codeword_o;
  logic         cw_valid_o;
  logic         cw_ready_i;

  modport master (
    output start_i, frozen_mask_i, info_bit_i, info_valid_i, cw_ready_i,
    input  start_ready_o, info_ready_o, codeword_o, cw_valid_o
  );

  modport slave (
    input  start_i, frozen_mask_i, info_bit_i, info_valid_i, cw_ready_i,
    output start_ready_o, info_ready_o, codeword_o, cw_valid_o
  );

endinterface

// File: rtl/polar_enc_butterfly.sv
// One stage of the F^{(x)n} transform: u[i] ^= u[i + 2^s] for every i with bit s clear.
module polar_enc_butterfly #(
  parameter int unsigned N       = 16,
  parameter int unsigned LOG2N   = 4,
  parameter int unsigned STAGE_W = 2
) (
  input  logic [N-1:0]       u_i,
  input  logic [STAGE_W-1:0] stage_i,
  output logic [N-1:0]       u_next_o
);

  // i | 2^s equals i + 2^s when bit s of i is clear, and is always in range.
  always_comb begin
    u_next_o = u_i;
    for (int unsigned s = 0; s < LOG2N; s++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (stage_i == STAGE_W'(s) && ((i >> s) & 1) == 0) begin
          u_next_o[i] = u_i[i] ^ u_i[i | (1 << s)];
        end
      end
    end
  end

endmodule

// File: rtl/polar_encoder.sv
// Iterative polar encoder: builds u from frozen mask + info stream, runs one butterfly
// stage per cycle, then holds the codeword. POLAR_ENC_BITREV_EN bit-reverses the output.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  polar_encoder_if.slave bus
);

  localparam int unsigned LOG2N   = $clog2(N);
  localparam int unsigned IDX_W   = $clog2(N);
  localparam int unsigned STAGE_W = $clog2(LOG2N);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_LOAD   = LOAD;
  localparam logic [1:0] ST_ENCODE = ENCODE;
  localparam logic [1:0] ST_OUT    = OUT;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [N-1:0]       u_q, u_d;
  logic [N-1:0]       mask_q, mask_d;
  logic               start_ready_q, start_ready_d;
  logic               info_ready_q, info_ready_d;
  logic               cw_valid_q, cw_valid_d;
  logic [N-1:0]       u_bfly;
  logic [N-1:0]       cw_c;

  polar_enc_butterfly #(
    .N       (N),
    .LOG2N   (LOG2N),
    .STAGE_W (STAGE_W)
  ) u_bfly_stage (
    .u_i      (u_q),
    .stage_i  (stage_q),
    .u_next_o (u_bfly)
  );

  // Next-state, datapath and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    u_d     = u_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          mask_d  = bus.frozen_mask_i;
          u_d     = '0;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Frozen positions advance unconditionally; unfrozen ones wait for a valid bit.
        if (mask_q[idx_q] || bus.info_valid_i) begin
          u_d[idx_q] = ~mask_q[idx_q] & bus.info_bit_i;
          if (idx_q == IDX_W'(N - 1)) begin
            idx_d   = '0;
            stage_d = '0;
            state_d = ST_ENCODE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_ENCODE: begin
        u_d = u_bfly;
        if (stage_q == STAGE_W'(LOG2N - 1)) begin
          state_d = ST_OUT;
        end else begin
          stage_d = stage_q + STAGE_W'(1);
        end
      end
      ST_OUT: begin
        if (bus.cw_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    start_ready_d = (state_d == ST_IDLE);
    info_ready_d  = (state_d == ST_LOAD) && !mask_d[idx_d];
    cw_valid_d    = (state_d == ST_OUT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      stage_q       <= '0;
      u_q           <= '0;
      mask_q        <= '0;
      start_ready_q <= 1'b1;
      info_ready_q  <= 1'b0;
      cw_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stage_q       <= stage_d;
      u_q           <= u_d;
      mask_q        <= mask_d;
      start_ready_q <= start_ready_d;
      info_ready_q  <= info_ready_d;
      cw_valid_q    <= cw_valid_d;
    end
  end

`ifdef POLAR_ENC_BITREV_EN
  always_comb begin
    cw_c = '0;
    for (int unsigned j = 0; j < N; j++) begin
      cw_c[j] = u_q[IDX_W'(bitrev(j, LOG2N))];
    end
  end
`else
  assign cw_c = u_q;
`endif

  assign bus.start_ready_o = start_ready_q;
  assign bus.info_ready_o  = info_ready_q;
  assign bus.cw_valid_o    = cw_valid_q;
  assign bus.codeword_o    = cw_c;

endmodule
